// File: rtl/fault_campaign_mod.sv
// Fault-injection campaign engine: squares B, injects a fault into the product,
// reduces golden and faulted products modulo A bit-serially, and counts mismatches.
module fault_campaign_mod #(
    parameter int BW = 4,
    parameter int AW = 8,
    parameter int PW = 2 * BW,
    parameter int LW = $clog2(PW),
    parameter int CW = $clog2(3 * PW + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [LW-1:0] f_loc,
    input  logic [1:0]    f_type,
    input  logic          sweep,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] c,
    output logic [AW-1:0] y,
    output logic [AW-1:0] golden_y,
    output logic          mismatch,
    output logic          divzero,
    output logic [CW-1:0] detect_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INJECT,
        S_DIV,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [PW-1:0] m_q, m_d;
    logic [LW-1:0] loc_q, loc_d;
    logic [1:0]    type_q, type_d;
    logic          sweep_q, sweep_d;
    logic          dz_q, dz_d;
    logic [PW-1:0] c_q, c_d;
    logic [PW-1:0] csh_q, csh_d;
    logic [PW-1:0] msh_q, msh_d;
    logic [AW:0]   remc_q, remc_d;
    logic [AW:0]   remm_q, remm_d;
    logic [LW-1:0] bit_q, bit_d;
    logic [AW-1:0] y_q, y_d;
    logic [AW-1:0] gy_q, gy_d;
    logic          mis_q, mis_d;
    logic [CW-1:0] det_q, det_d;

    // One restoring step: shift in next dividend bit, subtract divisor if it fits.
    function automatic logic [AW:0] rstep(input logic [AW:0] r,
                                          input logic d,
                                          input logic [AW-1:0] dv);
        logic [AW:0] s;
        s = {r[AW-1:0], d};
        if (s >= {1'b0, dv}) s = s - {1'b0, dv};
        return s;
    endfunction

    logic [PW-1:0] cf;
    logic [AW-1:0] yv, gv;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        loc_d   = loc_q;
        type_d  = type_q;
        sweep_d = sweep_q;
        dz_d    = dz_q;
        c_d     = c_q;
        csh_d   = csh_q;
        msh_d   = msh_q;
        remc_d  = remc_q;
        remm_d  = remm_q;
        bit_d   = bit_q;
        y_d     = y_q;
        gy_d    = gy_q;
        mis_d   = mis_q;
        det_d   = det_q;
        cf      = m_q;
        yv      = y_q;
        gv      = gy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    m_d     = PW'(b) * PW'(b);
                    loc_d   = sweep ? '0 : f_loc;
                    type_d  = sweep ? 2'd1 : f_type;
                    sweep_d = sweep;
                    det_d   = '0;
                    dz_d    = (a == '0);
                    state_d = S_INJECT;
                end
            end
            S_INJECT: begin
                cf = m_q;
                if (32'(loc_q) < PW) begin
                    case (type_q)
                        2'd1:    cf[loc_q] = 1'b0;
                        2'd2:    cf[loc_q] = 1'b1;
                        2'd3:    cf[loc_q] = ~m_q[loc_q];
                        default: cf = m_q;
                    endcase
                end
                c_d     = cf;
                csh_d   = cf;
                msh_d   = m_q;
                remc_d  = '0;
                remm_d  = '0;
                bit_d   = '0;
                state_d = dz_q ? S_CHECK : S_DIV;
            end
            S_DIV: begin
                remc_d = rstep(remc_q, csh_q[PW-1], a_q);
                remm_d = rstep(remm_q, msh_q[PW-1], a_q);
                csh_d  = csh_q << 1;
                msh_d  = msh_q << 1;
                bit_d  = bit_q + 1'b1;
                if (bit_q == LW'(PW - 1)) state_d = S_CHECK;
            end
            S_CHECK: begin
                yv    = dz_q ? AW'(c_q) : remc_q[AW-1:0];
                gv    = dz_q ? AW'(m_q) : remm_q[AW-1:0];
                y_d   = yv;
                gy_d  = gv;
                mis_d = (yv != gv);
                if ((yv != gv) && (det_q != '1)) det_d = det_q + 1'b1;
                state_d = S_DONE;
                if (sweep_q) begin
                    if (type_q != 2'd3) begin
                        type_d  = type_q + 2'd1;
                        state_d = S_INJECT;
                    end else if (loc_q != LW'(PW - 1)) begin
                        type_d  = 2'd1;
                        loc_d   = loc_q + 1'b1;
                        state_d = S_INJECT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            loc_q   <= '0;
            type_q  <= '0;
            sweep_q <= 1'b0;
            dz_q    <= 1'b0;
            c_q     <= '0;
            csh_q   <= '0;
            msh_q   <= '0;
            remc_q  <= '0;
            remm_q  <= '0;
            bit_q   <= '0;
            y_q     <= '0;
            gy_q    <= '0;
            mis_q   <= 1'b0;
            det_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            loc_q   <= loc_d;
            type_q  <= type_d;
            sweep_q <= sweep_d;
            dz_q    <= dz_d;
            c_q     <= c_d;
            csh_q   <= csh_d;
            msh_q   <= msh_d;
            remc_q  <= remc_d;
            remm_q  <= remm_d;
            bit_q   <= bit_d;
            y_q     <= y_d;
            gy_q    <= gy_d;
            mis_q   <= mis_d;
            det_q   <= det_d;
        end
    end

    assign busy = (state_q == S_INJECT) || (state_q == S_DIV) || (state_q == S_CHECK);
    assign done = (state_q == S_DONE);
    assign c            = c_q;
    assign y            = y_q;
    assign golden_y     = gy_q;
    assign mismatch     = mis_q;
    assign divzero      = dz_q;
    assign detect_count = det_q;

endmodule
